// File: rtl/secuenciador_comparador_pkg.sv
// Shared definitions for the comparator scan controller.
//   REPOSO / BARRIDO / FIN : 2-bit state encodings (legacy-compatible constants)
//   ANCHO_OPERANDO         : default operand width of the comparator datapath
package secuenciador_comparador_pkg;

    localparam int unsigned ANCHO_OPERANDO = 6;

    localparam logic [1:0] REPOSO  = 2'd0;
    localparam logic [1:0] BARRIDO = 2'd1;
    localparam logic [1:0] FIN     = 2'd2;

endpackage

// File: rtl/contador_barrido.sv
// Operand register for the sweep: load at start, hold, or wrap-increment.
// Also keeps the captured last operand and flags when the sweep reaches it.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   Cargar       : capture Desde/Hasta, Estimulo <- Desde
//   Avanzar      : Estimulo <- Estimulo + 1 (mod 2^ANCHO)
//   Desde, Hasta : sweep bounds, sampled only on Cargar
//   Estimulo     : registered operand driven to the comparator
//   enFinal_c    : Estimulo equals the captured last operand (combinational)
module contador_barrido
    import secuenciador_comparador_pkg::*;
#(
    parameter int unsigned ANCHO = ANCHO_OPERANDO
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Cargar,
    input  logic             Avanzar,
    input  logic [ANCHO-1:0] Desde,
    input  logic [ANCHO-1:0] Hasta,
    output logic [ANCHO-1:0] Estimulo,
    output logic             enFinal_c
);

    logic [ANCHO-1:0] hastaCapturado;

    // Operand and bound registers; the natural overflow gives the wrap-around.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Estimulo       <= '0;
            hastaCapturado <= '0;
        end else if (Cargar) begin
            Estimulo       <= Desde;
            hastaCapturado <= Hasta;
        end else if (Avanzar) begin
            Estimulo       <= Estimulo + ANCHO'(1);
        end
    end

    assign enFinal_c = (Estimulo == hastaCapturado);

endmodule

// File: rtl/secuenciador_comparador.sv
// Scan controller: sweeps a programmable operand range through a comparator,
// counting matches and recording the first matching operand.
//   Clk, Reset_n        : clock, asynchronous active-low reset
//   Inicio              : start request, honoured only in REPOSO
//   Desde, Hasta        : first/last operand, captured at start
//   Pausa               : freezes the sweep while high
//   Estimulo            : operand driven to the comparator
//   RtaComparador       : comparator answer for the current Estimulo
//   Ocupado             : sweep in progress
//   Listo               : one-cycle pulse when results become valid
//   Coincidencias       : number of matching operands
//   PrimeraCoincidencia : first matching operand in sweep order
//   HuboCoincidencia    : at least one match occurred
module secuenciador_comparador
    import secuenciador_comparador_pkg::*;
#(
    parameter int unsigned ANCHO = ANCHO_OPERANDO
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Inicio,
    input  logic [ANCHO-1:0] Desde,
    input  logic [ANCHO-1:0] Hasta,
    input  logic             Pausa,
    output logic [ANCHO-1:0] Estimulo,
    input  logic             RtaComparador,
    output logic             Ocupado,
    output logic             Listo,
    output logic [ANCHO:0]   Coincidencias,
    output logic [ANCHO-1:0] PrimeraCoincidencia,
    output logic             HuboCoincidencia
);

    // One extra bit: a full-range sweep can match all 2^ANCHO operands.
    localparam int unsigned ANCHO_CONT = ANCHO + 1;

    logic [1:0]            estado;
    logic [1:0]            estadoSig;
    logic                  cargar;
    logic                  avanzar;
    logic                  enFinal;
    logic                  ocupadoSig;
    logic                  listoSig;
    logic [ANCHO_CONT-1:0] coincidenciasSig;
    logic [ANCHO-1:0]      primeraSig;
    logic                  huboSig;

    contador_barrido #(
        .ANCHO(ANCHO)
    ) uContador (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Cargar   (cargar),
        .Avanzar  (avanzar),
        .Desde    (Desde),
        .Hasta    (Hasta),
        .Estimulo (Estimulo),
        .enFinal_c(enFinal)
    );

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            estado <= REPOSO;
        end else begin
            estado <= estadoSig;
        end
    end

    // Next state, counter control and next values of the registered outputs.
    always_comb begin
        estadoSig        = estado;
        cargar           = 1'b0;
        avanzar          = 1'b0;
        ocupadoSig       = Ocupado;
        listoSig         = 1'b0;
        coincidenciasSig = Coincidencias;
        primeraSig       = PrimeraCoincidencia;
        huboSig          = HuboCoincidencia;

        case (estado)
            REPOSO: begin
                if (Inicio) begin
                    cargar           = 1'b1;
                    ocupadoSig       = 1'b1;
                    coincidenciasSig = '0;
                    primeraSig       = '0;
                    huboSig          = 1'b0;
                    estadoSig        = BARRIDO;
                end
            end
            BARRIDO: begin
                if (!Pausa) begin
                    if (RtaComparador) begin
                        coincidenciasSig = Coincidencias + ANCHO_CONT'(1);
                        if (!HuboCoincidencia) begin
                            primeraSig = Estimulo;
                            huboSig    = 1'b1;
                        end
                    end
                    if (enFinal) begin
                        estadoSig  = FIN;
                        ocupadoSig = 1'b0;
                        listoSig   = 1'b1;
                    end else begin
                        avanzar = 1'b1;
                    end
                end
            end
            FIN: begin
                estadoSig = REPOSO;
            end
            default: begin
                estadoSig  = REPOSO;
                ocupadoSig = 1'b0;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Ocupado             <= 1'b0;
            Listo               <= 1'b0;
            Coincidencias       <= '0;
            PrimeraCoincidencia <= '0;
            HuboCoincidencia    <= 1'b0;
        end else begin
            Ocupado             <= ocupadoSig;
            Listo               <= listoSig;
            Coincidencias       <= coincidenciasSig;
            PrimeraCoincidencia <= primeraSig;
            HuboCoincidencia    <= huboSig;
        end
    end

endmodule

// File: tb/tb_secuenciador_comparador.sv
// Directed bench for the comparator scan controller. The comparator is a
// behavioural stand-in: modo 0 flags only operand 22, modo 1 flags even
// operands, modo 2 flags every operand.
module tb_secuenciador_comparador;

    logic       Clk;
    logic       Reset_n;
    logic       Inicio;
    logic [5:0] Desde;
    logic [5:0] Hasta;
    logic       Pausa;
    logic [5:0] Estimulo;
    logic       RtaComparador;
    logic       Ocupado;
    logic       Listo;
    logic [6:0] Coincidencias;
    logic [5:0] PrimeraCoincidencia;
    logic       HuboCoincidencia;
    logic [1:0] modo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] desde;
        logic [5:0] hasta;
        logic [1:0] modo;
        int         lat;
        int         coinc;
        int         prim;
        int         hubo;
    } vec_t;

    vec_t tabla[7];

    secuenciador_comparador #(.ANCHO(6)) dut (
        .Clk                (Clk),
        .Reset_n            (Reset_n),
        .Inicio             (Inicio),
        .Desde              (Desde),
        .Hasta              (Hasta),
        .Pausa              (Pausa),
        .Estimulo           (Estimulo),
        .RtaComparador      (RtaComparador),
        .Ocupado            (Ocupado),
        .Listo              (Listo),
        .Coincidencias      (Coincidencias),
        .PrimeraCoincidencia(PrimeraCoincidencia),
        .HuboCoincidencia   (HuboCoincidencia)
    );

    assign RtaComparador = (modo == 2'd2) ? 1'b1 :
                           (modo == 2'd1) ? ~Estimulo[0] :
                           (Estimulo == 6'd22);

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nombre, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nombre, act, exp, $time);
        end
    endtask

    // Start a sweep, follow Estimulo cycle by cycle, then check results.
    task automatic correrBarrido(input vec_t v);
        int         c;
        logic [5:0] expEst;
        @(negedge Clk);
        Desde  = v.desde;
        Hasta  = v.hasta;
        modo   = v.modo;
        Inicio = 1'b1;
        @(posedge Clk);
        #1;
        Inicio = 1'b0;
        chk("ocupado_tras_inicio", int'(Ocupado), 1);
        c      = 0;
        expEst = v.desde;
        while (c < 300) begin
            chk("estimulo_secuencia", int'(Estimulo), int'(expEst));
            @(posedge Clk);
            #1;
            c++;
            if (Listo) break;
            expEst = expEst + 6'd1;
        end
        chk("latencia", c, v.lat);
        chk("coincidencias", int'(Coincidencias), v.coinc);
        chk("primera", int'(PrimeraCoincidencia), v.prim);
        chk("hubo", int'(HuboCoincidencia), v.hubo);
        chk("ocupado_en_fin", int'(Ocupado), 0);
        chk("estimulo_final", int'(Estimulo), int'(v.hasta));
        @(posedge Clk);
        #1;
        chk("listo_un_ciclo", int'(Listo), 0);
        chk("coinc_estable", int'(Coincidencias), v.coinc);
        chk("primera_estable", int'(PrimeraCoincidencia), v.prim);
    endtask

    initial begin
        int         c;
        logic [5:0] expPausa[8];
        vec_t       vFull;

        tabla[0] = '{desde: 6'd0,  hasta: 6'd63, modo: 2'd0, lat: 64, coinc: 1,  prim: 22, hubo: 1};
        tabla[1] = '{desde: 6'd23, hasta: 6'd63, modo: 2'd0, lat: 41, coinc: 0,  prim: 0,  hubo: 0};
        tabla[2] = '{desde: 6'd60, hasta: 6'd3,  modo: 2'd1, lat: 8,  coinc: 4,  prim: 60, hubo: 1};
        tabla[3] = '{desde: 6'd22, hasta: 6'd22, modo: 2'd0, lat: 1,  coinc: 1,  prim: 22, hubo: 1};
        tabla[4] = '{desde: 6'd63, hasta: 6'd63, modo: 2'd1, lat: 1,  coinc: 0,  prim: 0,  hubo: 0};
        tabla[5] = '{desde: 6'd1,  hasta: 6'd0,  modo: 2'd1, lat: 64, coinc: 32, prim: 2,  hubo: 1};
        tabla[6] = '{desde: 6'd5,  hasta: 6'd4,  modo: 2'd2, lat: 64, coinc: 64, prim: 5,  hubo: 1};
        vFull    = tabla[0];
        expPausa = '{6'd20, 6'd21, 6'd22, 6'd22, 6'd22, 6'd22, 6'd23, 6'd24};

        Reset_n = 1'b0;
        Inicio  = 1'b0;
        Pausa   = 1'b0;
        Desde   = '0;
        Hasta   = '0;
        modo    = 2'd0;

        repeat (3) @(posedge Clk);
        #1;
        chk("reset_estimulo", int'(Estimulo), 0);
        chk("reset_ocupado", int'(Ocupado), 0);
        chk("reset_listo", int'(Listo), 0);
        chk("reset_coinc", int'(Coincidencias), 0);
        chk("reset_primera", int'(PrimeraCoincidencia), 0);
        chk("reset_hubo", int'(HuboCoincidencia), 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            correrBarrido(tabla[i]);
        end

        // Pause at operand 22 for three cycles, plus an ignored mid-sweep start.
        @(negedge Clk);
        Desde  = 6'd20;
        Hasta  = 6'd24;
        modo   = 2'd0;
        Inicio = 1'b1;
        @(posedge Clk);
        #1;
        Inicio = 1'b0;
        c = 0;
        while (c < 50) begin
            if (c < 8) chk("pausa_estimulo", int'(Estimulo), int'(expPausa[c]));
            Pausa  = (c >= 2 && c < 5);
            Inicio = (c == 6);
            Desde  = (c == 6) ? 6'd0 : 6'd20;
            @(posedge Clk);
            #1;
            Inicio = 1'b0;
            Pausa  = 1'b0;
            c++;
            if (Listo) break;
        end
        chk("pausa_latencia", c, 8);
        chk("pausa_coinc", int'(Coincidencias), 1);
        chk("pausa_primera", int'(PrimeraCoincidencia), 22);
        chk("pausa_estimulo_final", int'(Estimulo), 24);
        @(posedge Clk);
        #1;
        chk("pausa_sin_reinicio", int'(Ocupado), 0);

        // Reset in the middle of a full sweep.
        @(negedge Clk);
        Desde  = 6'd0;
        Hasta  = 6'd63;
        modo   = 2'd0;
        Inicio = 1'b1;
        @(posedge Clk);
        #1;
        Inicio = 1'b0;
        c = 0;
        while (Estimulo != 6'd30 && c < 100) begin
            @(posedge Clk);
            #1;
            c++;
        end
        chk("alcanza_30", int'(Estimulo), 30);
        chk("coinc_antes_reset", int'(Coincidencias), 1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rst_async_estimulo", int'(Estimulo), 0);
        chk("rst_async_ocupado", int'(Ocupado), 0);
        chk("rst_async_coinc", int'(Coincidencias), 0);
        chk("rst_async_primera", int'(PrimeraCoincidencia), 0);
        chk("rst_async_hubo", int'(HuboCoincidencia), 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk);
            #1;
            chk("rst_sin_listo", int'(Listo), 0);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("post_reset_reposo", int'(Ocupado), 0);
        correrBarrido(vFull);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
